// File: rtl/core_pkg.sv
// Pipeline types shared by the RV32 core stages: the execute opcode, the decoded
// instruction, and the read->execute and execute->memory pipeline registers.
package core;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR,
        SLL, SRL, SRA,
        SLT, SLTU,
        PASS_B,
        MUL, MULH, MULHSU, MULHU,
        DIV, DIVU, REM, REMU
    } ex_op_t;

    typedef struct packed {
        ex_op_t          op;
        logic            use_pc;
        logic            has_imm;
        logic [XLEN-1:0] imm;
    } de_inst_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        de_inst_t        de_inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic            valid;
    } rd_ex_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        de_inst_t        de_inst;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_value;
        logic            valid;
    } ex_mem_t;

    localparam ex_mem_t ex_mem_rst = '0;

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage bus: the read->execute register, the execute->memory register and
// the stall handshake. The stage itself uses the slave view.
interface ex_stage_if;

    logic          en;
    logic          next_rdy;
    core::rd_ex_t  rd_ex;
    core::ex_mem_t ex_mem;
    logic          rdy;

    modport master (output en, output next_rdy, output rd_ex, input ex_mem, input rdy);
    modport slave  (input en, input next_rdy, input rd_ex, output ex_mem, output rdy);

endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: single-cycle ALU/shift/compare/multiply, plus an iterative
// restoring divider that stalls upstream through rdy while it runs.
module ex_stage
    import core::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);

    localparam int              CW        = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(DIV_CYCLES - 1);
    localparam logic [XLEN-1:0] SMIN      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t      r_state, w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_quo, r_rem, r_dvs;
    logic            r_neg_q, r_neg_r, r_is_rem;
    ex_mem_t         r_ex_mem;

    ex_op_t            w_op;
    logic              w_en, w_rdy, w_launch;
    logic [XLEN-1:0]   w_a, w_b, w_alu, w_div_res;
    logic [4:0]        w_sh;
    logic              w_is_div, w_div_signed, w_div_zero, w_div_ovf;
    logic              w_ma_signed, w_mb_signed;
    logic [2*XLEN-1:0] w_ax, w_bx, w_prod;
    logic [XLEN:0]     w_shift, w_diff;
    logic              w_qbit;

    // rst masks en so nothing is consumed while reset is held.
    assign w_en = bus.en & ~rst;
    assign w_op = bus.rd_ex.de_inst.op;
    assign w_a  = bus.rd_ex.de_inst.use_pc  ? bus.rd_ex.pc          : bus.rd_ex.rs1_value;
    assign w_b  = bus.rd_ex.de_inst.has_imm ? bus.rd_ex.de_inst.imm : bus.rd_ex.rs2_value;
    assign w_sh = w_b[4:0];

    assign w_is_div     = (w_op == DIV) || (w_op == DIVU) || (w_op == REM) || (w_op == REMU);
    assign w_div_signed = (w_op == DIV) || (w_op == REM);
    assign w_div_zero   = (w_b == '0);
    assign w_div_ovf    = w_div_signed && (w_a == SMIN) && (w_b == '1);
    assign w_launch     = w_en && bus.rd_ex.valid && w_is_div && !w_div_zero && !w_div_ovf;

    // One shared 64-bit multiplier; operand extension selects the MULH flavour.
    assign w_ma_signed = (w_op == MULH) || (w_op == MULHSU);
    assign w_mb_signed = (w_op == MULH);
    assign w_ax   = {{XLEN{w_ma_signed & w_a[XLEN-1]}}, w_a};
    assign w_bx   = {{XLEN{w_mb_signed & w_b[XLEN-1]}}, w_b};
    assign w_prod = w_ax * w_bx;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_alu = '0;
        case (w_op)
            ADD:    w_alu = w_a + w_b;
            SUB:    w_alu = w_a - w_b;
            AND:    w_alu = w_a & w_b;
            OR:     w_alu = w_a | w_b;
            XOR:    w_alu = w_a ^ w_b;
            SLL:    w_alu = w_a << w_sh;
            SRL:    w_alu = w_a >> w_sh;
            SRA:    w_alu = $signed(w_a) >>> w_sh;
            SLT:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            SLTU:   w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
            PASS_B: w_alu = w_b;
            MUL:    w_alu = w_prod[XLEN-1:0];
            MULH, MULHSU, MULHU: w_alu = w_prod[2*XLEN-1:XLEN];
            // Only the special-case divides complete here; the rest go through the FSM.
            DIV, DIVU: w_alu = w_div_zero ? '1 : SMIN;
            REM, REMU: w_alu = w_div_zero ? w_a : '0;
            default:   w_alu = '0;
        endcase
    end

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_qbit  = ~w_diff[XLEN];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_launch) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (!w_en)                       w_state_nxt = S_IDLE;
                else if (r_count == LAST_ITER)   w_state_nxt = S_DONE;
            end
            S_DONE: if (!w_en || bus.next_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_rdy = w_en && bus.next_rdy &&
                   ((r_state == S_DONE) || ((r_state == S_IDLE) && !w_launch));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_launch) r_count <= '0;
            else if (r_state == S_BUSY)        r_count <= r_count + CW'(1);
        end
    end

    // NOTE: divider datapath has no reset; it is always loaded at launch before it is read.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_launch) begin
            r_quo    <= (w_div_signed && w_a[XLEN-1]) ? -w_a : w_a;
            r_dvs    <= (w_div_signed && w_b[XLEN-1]) ? -w_b : w_b;
            r_rem    <= '0;
            r_neg_q  <= w_div_signed && (w_a[XLEN-1] ^ w_b[XLEN-1]);
            r_neg_r  <= w_div_signed && w_a[XLEN-1];
            r_is_rem <= (w_op == REM) || (w_op == REMU);
        end else if (r_state == S_BUSY) begin
            r_rem <= w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_qbit};
        end
    end

    // Remainder follows the dividend's sign, quotient the XOR of both signs.
    assign w_div_res = r_is_rem ? (r_neg_r ? -r_rem : r_rem)
                                : (r_neg_q ? -r_quo : r_quo);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_mem <= ex_mem_rst;
        end else if (w_rdy) begin
            r_ex_mem.inst      <= bus.rd_ex.inst;
            r_ex_mem.pc        <= bus.rd_ex.pc;
            r_ex_mem.de_inst   <= bus.rd_ex.de_inst;
            r_ex_mem.result    <= (r_state == S_DONE) ? w_div_res : w_alu;
            r_ex_mem.rs2_value <= bus.rd_ex.rs2_value;
            r_ex_mem.valid     <= w_en && bus.rd_ex.valid;
        end
    end

    assign bus.ex_mem = r_ex_mem;
    assign bus.rdy    = w_rdy;

endmodule
